// File: rtl/exu_muldiv_if.sv
// exu_muldiv_if: request/response bundle between IDU, the muldiv unit and LSU/WBU.
// slave = the muldiv unit, master = the pipeline around it.
interface exu_muldiv_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) ();
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_func;
  logic [XLEN-1:0] i_a;
  logic [XLEN-1:0] i_b;
  logic [RD_W-1:0] i_reg_rd;
  logic [XLEN-1:0] i_pc;
  logic            i_flush;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [RD_W-1:0] o_reg_rd;
  logic [XLEN-1:0] o_pc;
  logic            o_busy;

  modport slave (
    input  i_valid, i_func, i_a, i_b, i_reg_rd, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_reg_rd, o_pc, o_busy
  );

  modport master (
    output i_valid, i_func, i_a, i_b, i_reg_rd, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_reg_rd, o_pc, o_busy
  );
endinterface

// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative RV-M shift-add multiplier / restoring divider.
// Define MULDIV_EARLY_OUT_EN to finish zero multiplies and |a|<|b| divides in one cycle.
module exu_muldiv #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic         i_clock,
  input logic         i_reset,
  exu_muldiv_if.slave io
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        func_q;
  logic              div_q;
  logic              neg_q;
  logic              rneg_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic              valid_q;
  logic              ready_q;
  logic              busy_q;
  logic [XLEN-1:0]   res_q;
  logic [XLEN-1:0]   pc_q;
  logic [RD_W-1:0]   rd_q;

  assign io.o_valid  = valid_q;
  assign io.o_ready  = ready_q;
  assign io.o_busy   = busy_q;
  assign io.o_result = res_q;
  assign io.o_reg_rd = rd_q;
  assign io.o_pc     = pc_q;

  logic            accept_d;
  logic            a_sgn_d;
  logic            b_sgn_d;
  logic            sa_d;
  logic            sb_d;
  logic            dz_d;
  logic            ovf_d;
  logic            early_d;
  logic            spec_d;
  logic [XLEN-1:0] ma_d;
  logic [XLEN-1:0] mb_d;
  logic [XLEN-1:0] spec_res_d;

  always_comb begin
    accept_d = io.i_valid && ready_q && !io.i_flush;
    a_sgn_d  = io.i_func inside {3'b001, 3'b010, 3'b100, 3'b110};
    b_sgn_d  = io.i_func inside {3'b001, 3'b100, 3'b110};
    sa_d     = a_sgn_d && io.i_a[XLEN-1];
    sb_d     = b_sgn_d && io.i_b[XLEN-1];
    ma_d     = sa_d ? -io.i_a : io.i_a;
    mb_d     = sb_d ? -io.i_b : io.i_b;
    dz_d     = io.i_func[2] && (io.i_b == '0);
    ovf_d    = (io.i_func inside {3'b100, 3'b110})
               && (io.i_a == MIN_NEG) && (io.i_b == '1);
`ifdef MULDIV_EARLY_OUT_EN
    early_d  = io.i_func[2] ? (ma_d < mb_d)
                            : ((io.i_a == '0) || (io.i_b == '0));
`else
    early_d  = 1'b0;
`endif
    spec_d   = dz_d || ovf_d || early_d;
    if (dz_d) begin
      spec_res_d = io.i_func[1] ? io.i_a : '1;
    end else if (ovf_d) begin
      spec_res_d = io.i_func[1] ? '0 : io.i_a;
    end else if (io.i_func[2]) begin
      spec_res_d = io.i_func[1] ? io.i_a : '0;
    end else begin
      spec_res_d = '0;
    end
  end

  logic [XLEN:0]     msum_d;
  logic [XLEN:0]     dtrial_d;
  logic [2*XLEN-1:0] acc_n;
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   quo_d;
  logic [XLEN-1:0]   rem_d;
  logic [XLEN-1:0]   fin_d;

  // acc holds {hi, multiplier} for multiply and {partial rem, dividend} for divide
  always_comb begin
    msum_d   = {1'b0, acc_q[2*XLEN-1:XLEN]}
               + (acc_q[0] ? {1'b0, opb_q} : '0);
    dtrial_d = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
    if (div_q) begin
      acc_n = dtrial_d[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                             : {dtrial_d[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_n = {msum_d, acc_q[XLEN-1:1]};
    end
    prod_d = neg_q  ? -acc_n : acc_n;
    quo_d  = neg_q  ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    rem_d  = rneg_q ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    fin_d  = '0;
    unique case (1'b1)
      !func_q[2] && (func_q[1:0] == 2'b00): fin_d = prod_d[XLEN-1:0];
      !func_q[2] && (func_q[1:0] != 2'b00): fin_d = prod_d[2*XLEN-1:XLEN];
      func_q[2] && !func_q[1]:              fin_d = quo_d;
      func_q[2] && func_q[1]:               fin_d = rem_d;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      func_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      opb_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      res_q   <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_d) begin
            func_q  <= io.i_func;
            rd_q    <= io.i_reg_rd;
            pc_q    <= io.i_pc;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (spec_d) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              res_q   <= spec_res_d;
            end else begin
              state_q <= CALC;
              cnt_q   <= CNT_W'(XLEN);
              div_q   <= io.i_func[2];
              neg_q   <= sa_d ^ sb_d;
              rneg_q  <= sa_d;
              acc_q   <= {{XLEN{1'b0}}, ma_d};
              opb_q   <= mb_d;
            end
          end
        end
        CALC: begin
          if (io.i_flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              res_q   <= fin_d;
            end
          end
        end
        DONE: begin
          if (io.i_flush || io.i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
